cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, one or more groups per pipeline stage. It is the streaming successor of the 4-bit registered CLA. It registers operands, ripples the group carry stage-to-stage through registers, and produces sum, carry, signed-overflow and zero flags. Independent valid/ready handshakes on input and output allow it to sit in datapath pipelines.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of 4*GPS, otherwise elaboration fails.
- GPS, 1, 4-bit CLA groups evaluated per stage; number of slices S = WIDTH/(4*GPS).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in (ignored when sub=1).
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

## Operation
- Ranks 0..S of registers, each with a valid bit; rank S is the output register.
- Rank 0 captures a, b^{WIDTH{sub}}, carry = sub ? 1 : cin.
- Slice k (1..S) is combinational between rank k-1 and rank k. It computes GPS groups of sum bits using 4-bit P/G lookahead from the carried-in bit, and passes the group carry-out plus the untouched upper operand bits and lower sum bits to rank k.
- Within a group: P=A^B, G=A&B, full lookahead carries C1..C4, S=P^C. Groups within a slice chain C4 to the next group's C0.
- Slice S also records the carry into the MSB for ovf. zero is computed from the final sum and registered in rank S.
- Flow: rank k loads when it is empty or rank k's content moves on this cycle. Rank S moves on when out_ready=1.
- Bubbles collapse. in_ready = rank 0 loads; it is combinational from out_ready through the valid chain.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- Order preserved. No beat is dropped or duplicated.
- Simultaneous accept and deliver on a full pipe is allowed: every rank shifts.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, so out_valid=0. sum=0, cout=0, ovf=0, zero=0. in_ready=1 once reset is released.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+S, i.e. S+1 register ranks. Defaults give 4 slices and 5 ranks.
- Throughput: one beat per cycle while out_ready=1.
- Capacity: S+1 beats.
- While out_valid=1 and out_ready=0, sum, cout, ovf and zero are held stable.
- Reset mid-operation discards all in-flight beats. No stale result emerges after release.
- Width: internal carry chain is WIDTH+1 bits. Results wrap modulo 2^WIDTH.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, sum=0, all flags 0. in_ready=1 after release.
- Add wrap: a=16'hFFFF, b=16'h0001, cin=0, sub=0 accepted at edge N -> out_valid at edge N+4, sum=16'h0000, cout=1, ovf=0, zero=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0, ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Stream: 200 random beats, random sub/cin, out_ready=1 -> one result per cycle after 5-cycle fill, in order, matching the reference model. in_ready stays 1.
- Backpressure: stream with out_ready=0 for 12 cycles -> exactly 5 beats accepted, then in_ready=0 and outputs held stable. With random out_ready afterwards, all beats drain in order with no loss or duplication. Repeat with GPS=2, WIDTH=32.
- Reset mid-flight: 3 beats in pipe, pulse rst_n low mid-cycle -> out_valid drops immediately. After release, only beats accepted afterwards appear.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// Operand/result stream bundle for cla_pipe_adder: valid/ready on the operand side
// and on the result side, with the operand and flag buses they qualify.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one slice of GPS 4-bit CLA groups per
// stage, group carry registered between ranks, elastic valid/ready flow with bubble collapse.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int SW = 4 * GPS;
    localparam int S  = WIDTH / SW;

    if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*GPS");
    end

    logic             r_v [0:S];
    logic [WIDTH-1:0] r_s [0:S];
    logic             r_c [0:S];
    logic [WIDTH-1:0] r_a [0:S-1];
    logic [WIDTH-1:0] r_b [0:S-1];
    logic             r_ovf;
    logic             r_zero;

    logic             load  [0:S];
    logic [WIDTH-1:0] nxt_s [1:S];
    logic             nxt_c [1:S];
    logic             c_msb;

    // Returns {carry into bit 3, carry out, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c3, c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // A rank may load when empty or when everything downstream of it advances.
    always_comb begin : flow
        logic go;
        go = bus.out_ready;
        for (int k = S; k >= 0; k--) begin
            load[k] = !r_v[k] || go;
            go      = load[k];
        end
    end

    always_comb begin : slices
        logic [WIDTH-1:0] s;
        logic             c;
        logic [5:0]       r;
        int               base;
        s     = '0;
        c     = 1'b0;
        r     = '0;
        base  = 0;
        c_msb = 1'b0;
        for (int k = 1; k <= S; k++) begin
            s = r_s[k-1];
            c = r_c[k-1];
            for (int g = 0; g < GPS; g++) begin
                base          = ((k - 1) * GPS + g) * 4;
                r             = cla4(r_a[k-1][base +: 4], r_b[k-1][base +: 4], c);
                s[base +: 4]  = r[3:0];
                c             = r[4];
                if (k == S && g == GPS - 1) c_msb = r[5];
            end
            nxt_s[k] = s;
            nxt_c[k] = c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= S; k++) begin
                r_v[k] <= 1'b0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            for (int k = 0; k < S; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (load[0]) begin
                r_v[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_a[0] <= bus.a;
                    r_b[0] <= bus.b ^ {WIDTH{bus.sub}};
                    r_c[0] <= bus.sub | bus.cin;
                end
            end
            for (int k = 1; k <= S; k++) begin
                if (load[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_s[k] <= nxt_s[k];
                        r_c[k] <= nxt_c[k];
                    end
                end
            end
            for (int k = 1; k < S; k++) begin
                if (load[k] && r_v[k-1]) begin
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                end
            end
            if (load[S] && r_v[S-1]) begin
                r_ovf  <= c_msb ^ nxt_c[S];
                r_zero <= (nxt_s[S] == '0);
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = r_v[S];
    assign bus.sum       = r_s[S];
    assign bus.cout      = r_c[S];
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Drives a 16-bit/GPS=1 and a 32-bit/GPS=2 instance in lockstep and scores every
// delivered result against an arithmetic reference model.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
    cla_pipe_adder_if #(.WIDTH(32)) bus32 ();

    cla_pipe_adder #(.WIDTH(16), .GPS(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    cla_pipe_adder #(.WIDTH(32), .GPS(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc16 = 0;
    int          acc32 = 0;
    int          a0, b0;
    logic [34:0] q16[$];
    logic [34:0] q32[$];
    int          t16[$];
    int          t32[$];
    bit          chk_lat, hold_chk, held_ok, use_dir;
    logic [34:0] dir16, dir32, held16, held32;

    // Expected {zero, ovf, cout, sum} for a w-bit add/subtract, plain arithmetic.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [32:0] t;
        logic [31:0] mask, am, bm, s;
        logic        co, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        am   = a & mask;
        bm   = (sub ? ~b : b) & mask;
        t    = {1'b0, am} + {1'b0, bm} + {32'h0, (sub ? 1'b1 : cin)};
        s    = t[31:0] & mask;
        co   = t[w];
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {(s == 32'h0), ov, co, s};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input bit r);
        bus16.out_ready = r;
        bus32.out_ready = r;
    endtask

    task automatic drive_rand(input bit v);
        logic ci, sb;
        bus16.in_valid = v;
        bus32.in_valid = v;
        bus16.a = 16'($urandom);
        bus16.b = 16'($urandom);
        bus32.a = $urandom;
        bus32.b = $urandom;
        if ($urandom_range(0, 7) == 0) begin
            bus16.a = 16'hFFFF;
            bus32.a = 32'hFFFF_FFFF;
        end
        if ($urandom_range(0, 7) == 0) begin
            bus16.b = bus16.a;
            bus32.b = bus32.a;
        end
        ci = 1'($urandom);
        sb = 1'($urandom);
        bus16.cin = ci;
        bus32.cin = ci;
        bus16.sub = sb;
        bus32.sub = sb;
    endtask

    task automatic cycle();
        logic [34:0] e;
        logic [34:0] cur16, cur32;
        int          t;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            cur16 = {bus16.zero, bus16.ovf, bus16.cout, 16'h0, bus16.sum};
            cur32 = {bus32.zero, bus32.ovf, bus32.cout, bus32.sum};
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(use_dir ? dir16
                              : model(16, {16'h0, bus16.a}, {16'h0, bus16.b}, bus16.cin, bus16.sub));
                t16.push_back(cyc);
                acc16++;
            end
            if (bus32.in_valid && bus32.in_ready) begin
                q32.push_back(use_dir ? dir32 : model(32, bus32.a, bus32.b, bus32.cin, bus32.sub));
                t32.push_back(cyc);
                acc32++;
            end
            if (bus16.out_valid && bus16.out_ready) begin
                check("q16_nonempty", 64'(q16.size() > 0), 64'd1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    t = t16.pop_front();
                    check("res16", 64'(cur16), 64'(e));
                    if (chk_lat) check("lat16", 64'(cyc - t), 64'd5);
                end
            end
            if (bus32.out_valid && bus32.out_ready) begin
                check("q32_nonempty", 64'(q32.size() > 0), 64'd1);
                if (q32.size() > 0) begin
                    e = q32.pop_front();
                    t = t32.pop_front();
                    check("res32", 64'(cur32), 64'(e));
                    if (chk_lat) check("lat32", 64'(cyc - t), 64'd5);
                end
            end
            if (hold_chk && bus16.out_valid && !bus16.out_ready) begin
                if (held_ok) begin
                    check("hold16", 64'(cur16), 64'(held16));
                    check("hold32", 64'(cur32), 64'(held32));
                end
                held16  = cur16;
                held32  = cur32;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a16, input logic [15:0] b16,
                        input logic [31:0] a32, input logic [31:0] b32,
                        input logic ci, input logic sb,
                        input logic [34:0] e16, input logic [34:0] e32);
        int n16, n32;
        n16 = acc16;
        n32 = acc32;
        bus16.a = a16;  bus16.b = b16;  bus16.cin = ci;  bus16.sub = sb;
        bus32.a = a32;  bus32.b = b32;  bus32.cin = ci;  bus32.sub = sb;
        bus16.in_valid = 1'b1;
        bus32.in_valid = 1'b1;
        use_dir = 1'b1;
        dir16   = e16;
        dir32   = e32;
        cycle();
        use_dir = 1'b0;
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        check("dir_acc16", 64'(acc16 - n16), 64'd1);
        check("dir_acc32", 64'(acc32 - n32), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        set_ready(1'b1);
        while ((q16.size() > 0 || q32.size() > 0) && n < 40) begin
            cycle();
            n++;
        end
        check("drain16_left", 64'(q16.size()), 64'd0);
        check("drain32_left", 64'(q32.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        use_dir  = 1'b0;
        chk_lat  = 1'b0;
        hold_chk = 1'b0;
        held_ok  = 1'b0;
        dir16    = '0;
        dir32    = '0;
        held16   = '0;
        held32   = '0;
        set_ready(1'b1);
        drive_rand(1'b1);

        repeat (3) begin
            cycle();
            check("rst16", 64'({bus16.out_valid, bus16.zero, bus16.ovf, bus16.cout, bus16.sum}), 64'd0);
            check("rst32", 64'({bus32.out_valid, bus32.zero, bus32.ovf, bus32.cout, bus32.sum}), 64'd0);
        end
        rst_n = 1'b1;
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        #1;
        check("rdy16_after_rst", 64'(bus16.in_ready), 64'd1);
        check("rdy32_after_rst", 64'(bus32.in_ready), 64'd1);

        chk_lat = 1'b1;
        send(16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             {3'b101, 32'h0000_0000}, {3'b101, 32'h0000_0000});
        drain();
        send(16'h0005, 16'h0007, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
             {3'b000, 32'h0000_FFFE}, {3'b000, 32'hFFFF_FFFE});
        send(16'h8000, 16'h0001, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
             {3'b011, 32'h0000_7FFF}, {3'b011, 32'h7FFF_FFFF});
        drain();

        a0 = acc16;
        b0 = acc32;
        for (int i = 0; i < 200; i++) begin
            drive_rand(1'b1);
            cycle();
            check("stream_rdy16", 64'(bus16.in_ready), 64'd1);
            check("stream_rdy32", 64'(bus32.in_ready), 64'd1);
        end
        drain();
        check("stream_cnt16", 64'(acc16 - a0), 64'd200);
        check("stream_cnt32", 64'(acc32 - b0), 64'd200);

        chk_lat  = 1'b0;
        hold_chk = 1'b1;
        held_ok  = 1'b0;
        set_ready(1'b0);
        a0 = acc16;
        b0 = acc32;
        repeat (12) begin
            drive_rand(1'b1);
            cycle();
        end
        check("bp_acc16", 64'(acc16 - a0), 64'd5);
        check("bp_acc32", 64'(acc32 - b0), 64'd5);
        check("bp_rdy16", 64'(bus16.in_ready), 64'd0);
        check("bp_rdy32", 64'(bus32.in_ready), 64'd0);
        for (int i = 0; i < 80; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            set_ready(1'($urandom_range(0, 1)));
            cycle();
        end
        hold_chk = 1'b0;
        drain();

        set_ready(1'b0);
        repeat (3) begin
            drive_rand(1'b1);
            cycle();
        end
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        repeat (5) cycle();
        check("mid_pre16", 64'(bus16.out_valid), 64'd1);
        check("mid_pre32", 64'(bus32.out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_drop16", 64'(bus16.out_valid), 64'd0);
        check("mid_drop32", 64'(bus32.out_valid), 64'd0);
        q16.delete();
        t16.delete();
        q32.delete();
        t32.delete();
        held_ok = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        set_ready(1'b1);
        chk_lat = 1'b1;
        a0 = acc16;
        b0 = acc32;
        repeat (2) begin
            drive_rand(1'b1);
            cycle();
        end
        drain();
        check("mid_cnt16", 64'(acc16 - a0), 64'd2);
        check("mid_cnt32", 64'(acc32 - b0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
